uart_transmitter: RTL

APB-programmed UART transmitter; the transmit counterpart of the UART receiver on the same peripheral bus. A CPU write to the TX address loads a one-byte holding register. The block serialises it as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit) on `tx_serial`. While the holding register is occupied, the block inserts APB wait states.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_transmitter_if.sv | 23 ++
 rtl/uart_bit_timer.sv | 42 ++++
 rtl/uart_transmitter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver on the peripheral bus.
package uart_pkg;

    // Serial line state machine, common to both directions.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_e;

    // Address bit that routes an access to the transmitter (1) or the receiver (0).
    localparam int UART_TX_ADDR_BIT = 7;

    // Bit positions within the TX status word.
    localparam int STAT_BUSY      = 0;
    localparam int STAT_HOLD_FULL = 1;

    // Bus widths.
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

endpackage

// File: rtl/uart_transmitter_if.sv
// APB slave port of the UART, grouped so the CPU side and the UART side share one bundle.
interface uart_transmitter_if;
    import uart_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Divides the bus clock down to one serial bit period; bit_end_o marks the last
// clock of each bit. Shared by the transmitter and the receiver.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_end_o
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o = enable_i && (cnt_q == LAST);

    // Next count: hold at zero while cleared, otherwise count and wrap on each bit end.
    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// APB-programmed 8N1 UART transmitter with a one-byte holding register in front of
// the shift register. Writes stall with PREADY=0 while the holding register is full.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    uart_transmitter_if.slave   apb,
    output logic                tx_serial,
    output logic                tx_busy,
    output logic                tx_done
);

    uart_state_e       state_q,     state_d;
    logic              hold_full_q, hold_full_d;
    logic [2:0]        bit_idx_q,   bit_idx_d;
    logic              tx_serial_q, tx_serial_d;
    logic [DATA_W-1:0] hold_data_q;
    logic [DATA_W-1:0] shift_q;

    logic              tx_access;
    logic              accept;
    logic              load;
    logic              bit_end;
    logic              addr_unused;

    // Bus decode: only PADDR[7]=1 belongs to the transmitter; the low address bits are don't-care.
    assign tx_access   = apb.PSEL && apb.PENABLE && apb.PADDR[UART_TX_ADDR_BIT];
    assign accept      = tx_access && apb.PWRITE && !hold_full_q;
    assign apb.PREADY  = !(tx_access && apb.PWRITE && hold_full_q);
    assign addr_unused = ^apb.PADDR[UART_TX_ADDR_BIT-1:0];

    assign tx_serial = tx_serial_q;
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = (state_q == STOP_BIT) && bit_end;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clear_i   (state_q == IDLE),
        .enable_i  (state_q != IDLE),
        .bit_end_o (bit_end)
    );

    // Status read: busy and hold_full during a TX read access phase, zero otherwise.
    always_comb begin
        apb.PRDATA = '0;
        if (tx_access && !apb.PWRITE) begin
            apb.PRDATA[STAT_BUSY]      = tx_busy;
            apb.PRDATA[STAT_HOLD_FULL] = hold_full_q;
        end
    end

    // Frame sequencing; the line level is computed for the next state so tx_serial stays registered.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        tx_serial_d = tx_serial_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                tx_serial_d = 1'b1;
                if (hold_full_q) begin
                    load        = 1'b1;
                    state_d     = START_BIT;
                    tx_serial_d = 1'b0;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d     = DATA_BITS;
                    bit_idx_d   = 3'd0;
                    tx_serial_d = shift_q[0];
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d     = STOP_BIT;
                        tx_serial_d = 1'b1;
                    end else begin
                        bit_idx_d   = bit_idx_q + 3'd1;
                        tx_serial_d = shift_q[bit_idx_d];
                    end
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        // Pending byte: start the next frame without an idle gap.
                        load        = 1'b1;
                        state_d     = START_BIT;
                        tx_serial_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        tx_serial_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                tx_serial_d = 1'b1;
            end
        endcase
    end

    // Holding register occupancy: a load and an accept are mutually exclusive on hold_full_q.
    always_comb begin
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end else if (accept) begin
            hold_full_d = 1'b1;
        end
    end

    // Control state; reset aborts any frame and drives the line idle immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            bit_idx_q   <= 3'd0;
            tx_serial_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            tx_serial_q <= tx_serial_d;
        end
    end

    // Byte payload: holding register captures the bus, shift register takes it at frame start.
    // NOTE: data-path registers have no reset; hold_full_q and state_q decide when their contents matter.
    always_ff @(posedge PCLK) begin
        if (accept) begin
            hold_data_q <= apb.PWDATA;
        end
        if (load) begin
            shift_q <= hold_data_q;
        end
    end

endmodule
